// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: requester ownership and access-sequencer states.
// Optional build macro used by the top level: VRAM_STATS_EN (CPU wait-cycle counter).
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_SCR  = 2'd2,
    OWN_CPU  = 2'd3
  } vram_owner_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } vram_state_t;

  localparam int VRAM_DATA_W = 8;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the three requester handshakes plus the SRAM pin-side signals.
// The arbiter takes the slave view; requesters / SRAM model take the master view.
interface vram_arbiter_if #(parameter int ADDR_W = 19);

  logic              init_req;
  logic [ADDR_W-1:0] init_addr;
  logic [7:0]        init_wdata;
  logic              init_ack;

  logic              scr_req;
  logic [ADDR_W-1:0] scr_addr;
  logic              scr_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_wmask;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;

  logic [7:0]        rdata;
  logic [ADDR_W-1:0] va_out;
  logic              va_oe;
  logic [7:0]        vd_out;
  logic              vd_oe;
  logic [7:0]        vd_in;
  logic              n_vrd;
  logic              n_vwr;
  logic              busy;

  modport slave (
    input  init_req, init_addr, init_wdata,
    input  scr_req, scr_addr,
    input  cpu_req, cpu_we, cpu_wmask, cpu_addr, cpu_wdata,
    input  vd_in,
    output init_ack, scr_ack, cpu_ack, rdata,
    output va_out, va_oe, vd_out, vd_oe, n_vrd, n_vwr, busy
  );

  modport master (
    output init_req, init_addr, init_wdata,
    output scr_req, scr_addr,
    output cpu_req, cpu_we, cpu_wmask, cpu_addr, cpu_wdata,
    output vd_in,
    input  init_ack, scr_ack, cpu_ack, rdata,
    input  va_out, va_oe, vd_out, vd_oe, n_vrd, n_vwr, busy
  );

endinterface

// File: rtl/vram_arbiter_prio_enc.sv
// Fixed-priority encoder for the VRAM requesters: loader beats screen beats CPU.
module vram_prio_enc
  import vram_arbiter_pkg::*;
(
  input  logic        i_init_req,
  input  logic        i_scr_req,
  input  logic        i_cpu_req,
  output vram_owner_t o_owner
);

  always_comb begin
    o_owner = OWN_NONE;
    if (i_init_req)      o_owner = OWN_INIT;
    else if (i_scr_req)  o_owner = OWN_SCR;
    else if (i_cpu_req)  o_owner = OWN_CPU;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates loader/screen/CPU onto the external SRAM with a SETUP/STROBE/HOLD sequencer.
// Build macro VRAM_STATS_EN adds a saturating CPU wait-cycle counter with synchronous clear.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int STROBE_CYCLES = 1,
  parameter int ADDR_W        = 19
) (
  input  logic          clk28,
  input  logic          rst,
  vram_arbiter_if.slave bus
`ifdef VRAM_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   cpu_wait_cnt
`endif
);

  generate
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 3) begin : g_bad_strobe
      $error("vram_arbiter: STROBE_CYCLES must be within 1..3");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_STROBE = STROBE;
  localparam logic [1:0] ST_HOLD   = HOLD;
  localparam logic [1:0] CNT_INIT  = 2'(STROBE_CYCLES - 1);

  logic [1:0]        r_state;
  vram_owner_t       r_owner;
  logic              r_we;
  logic              r_mask;
  logic [1:0]        r_strobeCnt;
  logic              r_n_vrd;
  logic              r_n_vwr;
  logic              r_va_oe;
  logic              r_vd_oe;
  logic [ADDR_W-1:0] r_va_out;
  logic [7:0]        r_vd_out;
  logic [7:0]        r_rdata;
  logic              r_init_ack;
  logic              r_scr_ack;
  logic              r_cpu_ack;

  vram_owner_t       w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic              w_we;
  logic              w_mask;

  vram_prio_enc u_prio (
    .i_init_req (bus.init_req),
    .i_scr_req  (bus.scr_req),
    .i_cpu_req  (bus.cpu_req),
    .o_owner    (w_grant)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    w_mask  = 1'b0;
    case (w_grant)
      OWN_INIT: begin
        w_addr  = bus.init_addr;
        w_wdata = bus.init_wdata;
        w_we    = 1'b1;
      end
      OWN_SCR:  w_addr = bus.scr_addr;
      OWN_CPU: begin
        w_addr  = bus.cpu_addr;
        w_wdata = bus.cpu_wdata;
        w_we    = bus.cpu_we;
        w_mask  = bus.cpu_wmask;
      end
      default: ;
    endcase
  end

  // Pins are registered so strobes never glitch; the read strobe already falls in SETUP,
  // the write strobe only in STROBE so address and data lead it by a full cycle.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_we        <= 1'b0;
      r_mask      <= 1'b0;
      r_strobeCnt <= '0;
      r_n_vrd     <= 1'b1;
      r_n_vwr     <= 1'b1;
      r_va_oe     <= 1'b0;
      r_vd_oe     <= 1'b0;
      r_va_out    <= '0;
      r_vd_out    <= '0;
      r_rdata     <= 8'hFF;
      r_init_ack  <= 1'b0;
      r_scr_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_init_ack <= 1'b0;
      r_scr_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant != OWN_NONE) begin
            r_state     <= ST_SETUP;
            r_owner     <= w_grant;
            r_we        <= w_we;
            r_mask      <= w_mask;
            r_strobeCnt <= CNT_INIT;
            r_va_oe     <= 1'b1;
            r_va_out    <= w_addr;
            if (w_we) begin
              r_vd_oe  <= 1'b1;
              r_vd_out <= w_wdata;
            end else begin
              r_n_vrd  <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          if (r_we && !(r_owner == OWN_CPU && r_mask)) r_n_vwr <= 1'b0;
        end
        ST_STROBE: begin
          if (r_strobeCnt == 2'd0) begin
            r_state <= ST_HOLD;
            r_n_vrd <= 1'b1;
            r_n_vwr <= 1'b1;
            if (!r_we) r_rdata <= bus.vd_in;
            case (r_owner)
              OWN_INIT: r_init_ack <= 1'b1;
              OWN_SCR:  r_scr_ack  <= 1'b1;
              OWN_CPU:  r_cpu_ack  <= 1'b1;
              default:  ;
            endcase
          end else begin
            r_strobeCnt <= r_strobeCnt - 2'd1;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_va_oe <= 1'b0;
          r_vd_oe <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.n_vrd    = r_n_vrd;
  assign bus.n_vwr    = r_n_vwr;
  assign bus.va_oe    = r_va_oe;
  assign bus.vd_oe    = r_vd_oe;
  assign bus.va_out   = r_va_out;
  assign bus.vd_out   = r_vd_out;
  assign bus.rdata    = r_rdata;
  assign bus.init_ack = r_init_ack;
  assign bus.scr_ack  = r_scr_ack;
  assign bus.cpu_ack  = r_cpu_ack;
  assign bus.busy     = (r_state != ST_IDLE);

`ifdef VRAM_STATS_EN
  logic [15:0] r_cpuWaitCnt;
  logic        w_cpuWaiting;

  // The grant cycle itself counts as served, not as waiting.
  assign w_cpuWaiting = bus.cpu_req && (r_owner != OWN_CPU) &&
                        !(r_state == ST_IDLE && w_grant == OWN_CPU);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_cpuWaitCnt <= '0;
    end else if (stats_clr) begin
      r_cpuWaitCnt <= '0;
    end else if (w_cpuWaiting && r_cpuWaitCnt != 16'hFFFF) begin
      r_cpuWaitCnt <= r_cpuWaitCnt + 16'd1;
    end
  end

  assign cpu_wait_cnt = r_cpuWaitCnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter (STROBE_CYCLES=1) with a behavioural SRAM model.
// Build with VRAM_STATS_EN defined to also exercise the CPU wait counter.
module tb_vram_arbiter;

  logic clk28;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] mem [0:(1<<19)-1];

  vram_arbiter_if #(.ADDR_W(19)) bus ();

`ifdef VRAM_STATS_EN
  logic        stats_clr;
  logic [15:0] cpu_wait_cnt;
`endif

  vram_arbiter #(.STROBE_CYCLES(1), .ADDR_W(19)) dut (
    .clk28 (clk28),
    .rst   (rst),
    .bus   (bus)
`ifdef VRAM_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .cpu_wait_cnt (cpu_wait_cnt)
`endif
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // SRAM model: combinational read while n_vrd is low, write sampled on clock while n_vwr is low.
  assign bus.vd_in = (!bus.n_vrd) ? mem[bus.va_out] : 8'hFF;

  always @(posedge clk28) begin
    if (!rst && !bus.n_vwr && bus.vd_oe) mem[bus.va_out] = bus.vd_out;
  end

  // Strobe exclusivity is watched on every cycle out of reset.
  always @(negedge clk28) begin
    if (!rst) begin
      checks++;
      if (!bus.n_vrd && !bus.n_vwr) begin
        failures++;
        $display("[TB] FAIL strobe_exclusive: n_vrd=%0b n_vwr=%0b required not both 0",
                 bus.n_vrd, bus.n_vwr);
      end
    end
  end

  typedef struct {
    logic        cpuReq;
    logic        cpuWe;
    logic        cpuWmask;
    logic [18:0] cpuAddr;
    logic [7:0]  cpuWdata;
    logic        eNvrd;
    logic        eNvwr;
    logic        eVaOe;
    logic        eVdOe;
    logic        eBusy;
    logic        eCpuAck;
    logic        chkRdata;
    logic [7:0]  eRdata;
  } vec_t;

  function automatic vec_t mk(logic req, logic we, logic wm, logic [18:0] addr,
                              logic [7:0] wd, logic evrd, logic evwr, logic evaoe,
                              logic evdoe, logic ebusy, logic eack,
                              logic chkRd, logic [7:0] erd);
    vec_t v;
    v.cpuReq = req;  v.cpuWe = we;  v.cpuWmask = wm;  v.cpuAddr = addr;  v.cpuWdata = wd;
    v.eNvrd = evrd;  v.eNvwr = evwr;  v.eVaOe = evaoe;  v.eVdOe = evdoe;
    v.eBusy = ebusy; v.eCpuAck = eack; v.chkRdata = chkRd; v.eRdata = erd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.cpu_req   = v.cpuReq;
    bus.cpu_we    = v.cpuWe;
    bus.cpu_wmask = v.cpuWmask;
    bus.cpu_addr  = v.cpuAddr;
    bus.cpu_wdata = v.cpuWdata;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs [12];
  int   initCnt, scrCnt, cpuCnt, initAt, scrAt, cpuAt;
  logic [7:0] scrData, cpuData;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.init_req = 1'b0;  bus.init_addr = '0;  bus.init_wdata = '0;
    bus.scr_req  = 1'b0;  bus.scr_addr  = '0;
    bus.cpu_req  = 1'b0;  bus.cpu_we    = 1'b0; bus.cpu_wmask = 1'b0;
    bus.cpu_addr = '0;    bus.cpu_wdata = '0;
`ifdef VRAM_STATS_EN
    stats_clr = 1'b0;
`endif
    mem[19'h7C123] = 8'hA5;
    mem[19'h40010] = 8'h00;
    mem[19'h00100] = 8'h00;
    mem[19'h00200] = 8'h22;
    mem[19'h00300] = 8'h33;

    // CPU read, CPU write, masked CPU write; each access SETUP/STROBE/HOLD then IDLE.
    vecs[0]  = mk(1, 0, 0, 19'h7C123, 8'h00, 0, 1, 1, 0, 1, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 19'h7C123, 8'h00, 0, 1, 1, 0, 1, 0, 0, 8'h00);
    vecs[2]  = mk(1, 0, 0, 19'h7C123, 8'h00, 1, 1, 1, 0, 1, 1, 1, 8'hA5);
    vecs[3]  = mk(0, 0, 0, 19'h7C123, 8'h00, 1, 1, 0, 0, 0, 0, 1, 8'hA5);
    vecs[4]  = mk(1, 1, 0, 19'h40010, 8'h3C, 1, 1, 1, 1, 1, 0, 0, 8'h00);
    vecs[5]  = mk(1, 1, 0, 19'h40010, 8'h3C, 1, 0, 1, 1, 1, 0, 0, 8'h00);
    vecs[6]  = mk(1, 1, 0, 19'h40010, 8'h3C, 1, 1, 1, 1, 1, 1, 0, 8'h00);
    vecs[7]  = mk(0, 1, 0, 19'h40010, 8'h3C, 1, 1, 0, 0, 0, 0, 1, 8'hA5);
    vecs[8]  = mk(1, 1, 1, 19'h40010, 8'h77, 1, 1, 1, 1, 1, 0, 0, 8'h00);
    vecs[9]  = mk(1, 1, 1, 19'h40010, 8'h77, 1, 1, 1, 1, 1, 0, 0, 8'h00);
    vecs[10] = mk(1, 1, 1, 19'h40010, 8'h77, 1, 1, 1, 1, 1, 1, 0, 8'h00);
    vecs[11] = mk(0, 1, 1, 19'h40010, 8'h77, 1, 1, 0, 0, 0, 0, 0, 8'h00);

    repeat (3) @(posedge clk28);
    @(negedge clk28);
    rst = 1'b0;
    @(negedge clk28);
    checkOutput("reset n_vrd",  32'(bus.n_vrd),  32'd1);
    checkOutput("reset n_vwr",  32'(bus.n_vwr),  32'd1);
    checkOutput("reset va_oe",  32'(bus.va_oe),  32'd0);
    checkOutput("reset vd_oe",  32'(bus.vd_oe),  32'd0);
    checkOutput("reset va_out", 32'(bus.va_out), 32'd0);
    checkOutput("reset vd_out", 32'(bus.vd_out), 32'd0);
    checkOutput("reset rdata",  32'(bus.rdata),  32'hFF);
    checkOutput("reset busy",   32'(bus.busy),   32'd0);
    checkOutput("reset acks",   32'({bus.init_ack, bus.scr_ack, bus.cpu_ack}), 32'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk28);
      checkOutput($sformatf("vec%0d n_vrd", i),   32'(bus.n_vrd),   32'(vecs[i].eNvrd));
      checkOutput($sformatf("vec%0d n_vwr", i),   32'(bus.n_vwr),   32'(vecs[i].eNvwr));
      checkOutput($sformatf("vec%0d va_oe", i),   32'(bus.va_oe),   32'(vecs[i].eVaOe));
      checkOutput($sformatf("vec%0d vd_oe", i),   32'(bus.vd_oe),   32'(vecs[i].eVdOe));
      checkOutput($sformatf("vec%0d busy", i),    32'(bus.busy),    32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d cpu_ack", i), 32'(bus.cpu_ack), 32'(vecs[i].eCpuAck));
      checkOutput($sformatf("vec%0d other_acks", i), 32'({bus.init_ack, bus.scr_ack}), 32'd0);
      if (vecs[i].eVaOe)
        checkOutput($sformatf("vec%0d va_out", i), 32'(bus.va_out), 32'(vecs[i].cpuAddr));
      if (vecs[i].eVdOe)
        checkOutput($sformatf("vec%0d vd_out", i), 32'(bus.vd_out), 32'(vecs[i].cpuWdata));
      if (vecs[i].chkRdata)
        checkOutput($sformatf("vec%0d rdata", i),  32'(bus.rdata),  32'(vecs[i].eRdata));
    end
    checkOutput("write mem[40010]", 32'(mem[19'h40010]), 32'h3C);

    // Contention: all three request in the same cycle; expect init@3, scr@7, cpu@11.
    bus.init_req = 1'b1;  bus.init_addr = 19'h00100;  bus.init_wdata = 8'h11;
    bus.scr_req  = 1'b1;  bus.scr_addr  = 19'h00200;
    bus.cpu_req  = 1'b1;  bus.cpu_we    = 1'b0;  bus.cpu_wmask = 1'b0;
    bus.cpu_addr = 19'h00300;
    initCnt = 0; scrCnt = 0; cpuCnt = 0; initAt = -1; scrAt = -1; cpuAt = -1;
    scrData = 8'h00; cpuData = 8'h00;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk28);
      if (bus.init_ack) begin initCnt++; initAt = cyc; bus.init_req = 1'b0; end
      if (bus.scr_ack)  begin scrCnt++;  scrAt  = cyc; scrData = bus.rdata; bus.scr_req = 1'b0; end
      if (bus.cpu_ack)  begin cpuCnt++;  cpuAt  = cyc; cpuData = bus.rdata; bus.cpu_req = 1'b0; end
    end
    checkOutput("contend init_ack count", 32'(initCnt), 32'd1);
    checkOutput("contend init_ack cycle", 32'(initAt),  32'd3);
    checkOutput("contend scr_ack count",  32'(scrCnt),  32'd1);
    checkOutput("contend scr_ack cycle",  32'(scrAt),   32'd7);
    checkOutput("contend cpu_ack count",  32'(cpuCnt),  32'd1);
    checkOutput("contend cpu_ack cycle",  32'(cpuAt),   32'd11);
    checkOutput("contend scr rdata",      32'(scrData), 32'h22);
    checkOutput("contend cpu rdata",      32'(cpuData), 32'h33);
    checkOutput("contend mem[00100]",     32'(mem[19'h00100]), 32'h11);

    // Reset asserted while the write strobe is low.
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b1;  bus.cpu_wmask = 1'b0;
    bus.cpu_addr = 19'h40030;  bus.cpu_wdata = 8'h99;
    @(negedge clk28);
    @(negedge clk28);
    checkOutput("rstmid strobe low", 32'(bus.n_vwr), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rstmid n_vwr",   32'(bus.n_vwr),   32'd1);
    checkOutput("rstmid va_oe",   32'(bus.va_oe),   32'd0);
    checkOutput("rstmid vd_oe",   32'(bus.vd_oe),   32'd0);
    checkOutput("rstmid busy",    32'(bus.busy),    32'd0);
    bus.cpu_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk28);
      checkOutput("rstmid ack in reset", 32'(bus.cpu_ack), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk28);
      checkOutput("rstmid ack after release", 32'(bus.cpu_ack), 32'd0);
      checkOutput("rstmid idle after release", 32'(bus.busy), 32'd0);
    end
    checkOutput("rstmid rdata", 32'(bus.rdata), 32'hFF);

`ifdef VRAM_STATS_EN
    stats_clr = 1'b1;
    @(negedge clk28);
    stats_clr = 1'b0;
    bus.scr_req = 1'b1;  bus.scr_addr = 19'h00200;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 19'h00300;
    repeat (20) @(negedge clk28);
    checkOutput("stats wait count", 32'(cpu_wait_cnt), 32'd20);
    stats_clr = 1'b1;
    @(negedge clk28);
    checkOutput("stats clear wins", 32'(cpu_wait_cnt), 32'd0);
    stats_clr = 1'b0;
    bus.scr_req = 1'b0;  bus.cpu_req = 1'b0;
    repeat (8) @(negedge clk28);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the single external 512K×8 SRAM (va[18:0]/vd[7:0], n_vrd/n_vwr) shared by three requesters: ROM-to-RAM loader (write-only), screen fetcher (read-only) and CPU memory path (read/write, ROM and RAM already resolved to a physical address).
- Sits between the memory-map logic in zx_ula and the SRAM pins.
- Replaces ad-hoc strobe equations with a fixed-priority arbiter plus an access state machine that guarantees address setup and data hold around every write strobe.

Parameters:
- STROBE_CYCLES, 1, clk28 cycles n_vrd/n_vwr stay asserted in STROBE (1..3).
- ADDR_W, 19, SRAM address width.

Ports:
- clk28  in  1  system clock, 28 MHz.
- rst  in  1  asynchronous reset, active-high.
- init_req  in  1  loader write request, level.
- init_addr  in  ADDR_W  loader address.
- init_wdata  in  8  loader data.
- init_ack  out  1  one-cycle pulse: loader write completed.
- scr_req  in  1  screen read request, level.
- scr_addr  in  ADDR_W  screen address.
- scr_ack  out  1  one-cycle pulse: rdata valid for screen.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_wmask  in  1  1 = suppress write strobe (read-only page); ack still given.
- cpu_addr  in  ADDR_W  CPU physical address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle pulse: CPU access completed / rdata valid.
- rdata  out  8  latched SRAM read data.
- va_out  out  ADDR_W  SRAM address.
- va_oe  out  1  1 = drive va.
- vd_out  out  8  SRAM write data.
- vd_oe  out  1  1 = drive vd.
- n_vrd  out  1  SRAM read strobe, active-low.
- n_vwr  out  1  SRAM write strobe, active-low.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, n_vrd=1, n_vwr=1, va_oe=0, vd_oe=0, va_out=0, vd_out=0, rdata=8'hFF, all acks 0, busy=0.
- Reset asserted mid-access: strobes deassert and buses release asynchronously; no ack is issued for the aborted access.
- Priority, evaluated only in IDLE: init > scr > cpu. No preemption once SETUP is entered.
- On grant, the owner, address, we and wdata are captured into registers; requester inputs are ignored until the next IDLE.
- IDLE -> SETUP (1 cycle):
  - va_oe=1 and va_out=captured address.
  - Read: n_vrd=0 from SETUP onward.
  - Write: vd_oe=1, vd_out=wdata, n_vwr still 1.
- SETUP -> STROBE (STROBE_CYCLES cycles, down-counter):
  - Read: n_vrd held 0.
  - Write: n_vwr=0, unless owner=cpu and cpu_wmask=1, in which case n_vwr stays 1.
- STROBE -> HOLD (1 cycle):
  - n_vrd=1 and n_vwr=1.
  - For reads, rdata is latched from vd on the clock edge leaving STROBE, and that owner's ack pulses during HOLD.
  - For writes, vd_oe and va_oe stay 1 through HOLD, and the write ack pulses in HOLD.
- HOLD -> IDLE:
  - va_oe=0 and vd_oe=0.
  - A still-asserted req is re-arbitrated in the same IDLE cycle; no back-to-back bypass of IDLE.
- Access latency: STROBE_CYCLES+2 cycles from grant to ack. Minimum period is STROBE_CYCLES+3 cycles.
- Ownership exclusivity: n_vrd and n_vwr are never both 0; vd_oe=1 only for write owners.
- Request protocol: each req must stay high until its ack. Dropping a req before grant cancels it silently; dropping it after grant is ignored.
- Simultaneous init_req and scr_req: init wins; scr waits.
- Starvation: cpu may starve while init or scr is continuously requesting; bounding that is the requesters' responsibility.
- STROBE_CYCLES outside 1..3: elaboration error.

Optional Feature:
- Macro: VRAM_STATS_EN.
- Defined:
  - Adds output cpu_wait_cnt[15:0], a saturating count (sticks at 16'hFFFF) of cycles with cpu_req=1 while not granted to cpu.
  - Adds input stats_clr, synchronous clear; clear wins over a same-cycle increment.
  - Reset value 0.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Shared package common:
  - vram_owner_t enum: OWN_NONE, OWN_INIT, OWN_SCR, OWN_CPU.
  - vram_state_t enum: IDLE, SETUP, STROBE, HOLD.
- One sub-module, vram_prio_enc: 3-input fixed-priority encoder returning vram_owner_t. It keeps priority order testable in isolation.
- Strobe FSM and capture registers stay in vram_arbiter.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 3 cycles, then release with no requests.
  - Required: n_vrd=n_vwr=1, va_oe=vd_oe=0, rdata=8'hFF, busy=0.
- CPU read, STROBE_CYCLES=1:
  - Stimulus: cpu_req=1, we=0, addr=19'h7C123; SRAM model returns 8'hA5.
  - Required: n_vrd low for exactly 2 cycles; cpu_ack pulses 3 cycles after grant; rdata=8'hA5.
- CPU write:
  - Stimulus: addr=19'h40010, wdata=8'h3C.
  - Required: n_vwr low for 1 cycle only; va and vd are stable 1 cycle before and after the strobe; model memory[0x40010]=8'h3C.
  - Repeat with cpu_wmask=1: n_vwr never falls, cpu_ack still pulses, memory unchanged.
- Contention:
  - Stimulus: init_req, scr_req and cpu_req all asserted in the same cycle.
  - Required: service order init, scr, cpu; each ack exactly once; cpu_ack at cycle 3×4 - 1 = 11 after the first grant.
- Reset mid-write:
  - Stimulus: assert rst while in STROBE.
  - Required: n_vwr=1 immediately (asynchronous), no ack issued, FSM returns to IDLE on release.
- VRAM_STATS_EN build:
  - Stimulus: scr_req held for 20 cycles with cpu_req=1.
  - Required: cpu_wait_cnt counts every cycle cpu is not granted; stats_clr returns it to 0.
